// File: rtl/cumulative_shift_gen_mc.sv
// Multi-channel cumulative circulant shift generator for a QC-LDPC layered decoder.
// Accumulates per-layer shifts modulo Z for each block column and produces the
// shortest-direction rotation for the barrel shifters. Single registered output
// stage with valid/ready handshake, layer/iteration tracking and input checking.
module cumulative_shift_gen_mc #(
   parameter int unsigned CH_NUM      = 4,
   parameter int unsigned SHIFT_WIDTH = 9,
   parameter int unsigned REF_WIDTH   = 9,
   parameter int unsigned LAYER_NUM   = 12,
   parameter int unsigned DEFAULT_Z   = 7
) (
   input  logic                             sys_clk,
   input  logic                             rst,
   input  logic [REF_WIDTH-1:0]             z_reconfig_i,
   input  logic [REF_WIDTH-1:0]             zHalf_reconfig_i,
   input  logic                             cfg_load_i,
   input  logic                             clr_i,
   input  logic                             in_valid_i,
   output logic                             in_ready_o,
   input  logic [CH_NUM*SHIFT_WIDTH-1:0]    shift_i,
   output logic                             out_valid_o,
   input  logic                             out_ready_i,
   output logic [CH_NUM*SHIFT_WIDTH-1:0]    cumulative_shift_o,
   output logic [CH_NUM*SHIFT_WIDTH-1:0]    rot_amt_o,
   output logic [CH_NUM-1:0]                rot_dir_o,
   output logic [$clog2(LAYER_NUM)-1:0]     layer_idx_o,
   output logic                             iter_end_o,
   output logic                             shift_err_o
);

   localparam int unsigned LW = $clog2(LAYER_NUM);
   // Common compare/arithmetic width: wide enough for Z, shifts and acc+shift.
   localparam int unsigned CW = ((SHIFT_WIDTH > REF_WIDTH) ? SHIFT_WIDTH : REF_WIDTH) + 1;
   localparam logic [LW-1:0]        LastLayer = LW'(LAYER_NUM - 1);
   localparam logic [REF_WIDTH-1:0] ZReset    = REF_WIDTH'(DEFAULT_Z);
   localparam logic [REF_WIDTH-1:0] ZHalfReset = REF_WIDTH'(DEFAULT_Z / 2);

   // Configuration and accumulator state
   logic [REF_WIDTH-1:0]                z_q, z_d;
   logic [REF_WIDTH-1:0]                zhalf_q, zhalf_d;
   logic [CH_NUM-1:0][SHIFT_WIDTH-1:0]  acc_q, acc_d;
   logic [LW-1:0]                       layer_q, layer_d;
   logic                                err_q, err_d;

   // Output register stage
   logic                                out_valid_q, out_valid_d;
   logic [CH_NUM-1:0][SHIFT_WIDTH-1:0]  cum_q, cum_d;
   logic [CH_NUM-1:0][SHIFT_WIDTH-1:0]  rot_amt_q, rot_amt_d;
   logic [CH_NUM-1:0]                   rot_dir_q, rot_dir_d;
   logic [LW-1:0]                       layer_idx_q, layer_idx_d;
   logic                                iter_end_q, iter_end_d;

   // Per-channel datapath results
   logic [CH_NUM-1:0][SHIFT_WIDTH-1:0]  chan_cum;
   logic [CH_NUM-1:0][SHIFT_WIDTH-1:0]  chan_amt;
   logic [CH_NUM-1:0]                   chan_dir;
   logic [CH_NUM-1:0]                   chan_illegal;
   logic [CW-1:0]                       s_ext, sum_ext, cum_ext, z_ext, zhalf_ext;

   logic                                accept;
   logic                                cfg_ok;
   logic [LW-1:0]                       layer_base;
   logic                                last_layer;

   assign in_ready_o = !out_valid_q || out_ready_i;
   assign accept     = in_valid_i && in_ready_o;
   assign cfg_ok     = cfg_load_i && !out_valid_q && !in_valid_i && (z_reconfig_i != '0);
   // A coincident clear makes the accepted beat start from acc=0, layer 0.
   assign layer_base = clr_i ? '0 : layer_q;
   assign last_layer = (layer_base == LastLayer);

   // Per-channel modular accumulation and shortest-rotation selection
   always_comb begin
      chan_cum     = '0;
      chan_amt     = '0;
      chan_dir     = '0;
      chan_illegal = '0;
      s_ext        = '0;
      sum_ext      = '0;
      cum_ext      = '0;
      z_ext        = CW'(z_q);
      zhalf_ext    = CW'(zhalf_q);
      for (int c = 0; c < CH_NUM; c++) begin
         s_ext = CW'(shift_i[c*SHIFT_WIDTH +: SHIFT_WIDTH]);
         if (s_ext >= z_ext) begin
            // Out-of-range shift contributes nothing but is flagged.
            chan_illegal[c] = 1'b1;
            s_ext           = '0;
         end
         sum_ext     = (clr_i ? '0 : CW'(acc_q[c])) + s_ext;
         cum_ext     = (sum_ext >= z_ext) ? (sum_ext - z_ext) : sum_ext;
         chan_cum[c] = SHIFT_WIDTH'(cum_ext);
         if (cum_ext > zhalf_ext) begin
            chan_dir[c] = 1'b1;
            chan_amt[c] = SHIFT_WIDTH'(z_ext - cum_ext);
         end else begin
            chan_dir[c] = 1'b0;
            chan_amt[c] = SHIFT_WIDTH'(cum_ext);
         end
      end
   end

   // Next-state for configuration, accumulators, layer counter and error flag
   always_comb begin
      z_d     = z_q;
      zhalf_d = zhalf_q;
      acc_d   = acc_q;
      layer_d = layer_q;
      err_d   = err_q;
      if (cfg_ok) begin
         z_d     = z_reconfig_i;
         zhalf_d = zHalf_reconfig_i;
         acc_d   = '0;
         layer_d = '0;
         err_d   = 1'b0;
      end else begin
         if (clr_i) begin
            acc_d   = '0;
            layer_d = '0;
         end else if (accept) begin
            if (last_layer) begin
               acc_d   = '0;
               layer_d = '0;
            end else begin
               acc_d   = chan_cum;
               layer_d = layer_base + LW'(1);
            end
         end
         if (accept && (|chan_illegal)) begin
            err_d = 1'b1;
         end
      end
   end

   // Next-state for the output register stage
   always_comb begin
      out_valid_d = out_valid_q;
      cum_d       = cum_q;
      rot_amt_d   = rot_amt_q;
      rot_dir_d   = rot_dir_q;
      layer_idx_d = layer_idx_q;
      iter_end_d  = iter_end_q;
      if (accept) begin
         out_valid_d = 1'b1;
         cum_d       = chan_cum;
         rot_amt_d   = chan_amt;
         rot_dir_d   = chan_dir;
         layer_idx_d = layer_base;
         iter_end_d  = last_layer;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         z_q         <= ZReset;
         zhalf_q     <= ZHalfReset;
         acc_q       <= '0;
         layer_q     <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         cum_q       <= '0;
         rot_amt_q   <= '0;
         rot_dir_q   <= '0;
         layer_idx_q <= '0;
         iter_end_q  <= 1'b0;
      end else begin
         z_q         <= z_d;
         zhalf_q     <= zhalf_d;
         acc_q       <= acc_d;
         layer_q     <= layer_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         cum_q       <= cum_d;
         rot_amt_q   <= rot_amt_d;
         rot_dir_q   <= rot_dir_d;
         layer_idx_q <= layer_idx_d;
         iter_end_q  <= iter_end_d;
      end
   end

   assign out_valid_o        = out_valid_q;
   assign cumulative_shift_o = cum_q;
   assign rot_amt_o          = rot_amt_q;
   assign rot_dir_o          = rot_dir_q;
   assign layer_idx_o        = layer_idx_q;
   assign iter_end_o         = iter_end_q;
   assign shift_err_o        = err_q;

endmodule

// File: doc/cumulative_shift_gen_mc.md
# cumulative_shift_gen_mc

Multi-channel, runtime-reconfigurable successor to the single-channel cumulative shift generator in the QC-LDPC layered decoder. For each of `CH_NUM` block columns it accumulates per-layer circulant shifts modulo the lifting size Z. It also emits the shortest-direction rotation (amount plus direction) for the barrel shifters. The block sits between the base-matrix ROM reader and the permutation network. It adds valid/ready flow control, layer/iteration tracking and input checking.

## Interface
- `CH_NUM`, 4: number of parallel channels (block columns).
- `SHIFT_WIDTH`, 9: width of each shift value.
- `REF_WIDTH`, 9: width of the Z and floor(Z/2) configuration values.
- `LAYER_NUM`, 12: number of layers per decoding iteration.
- `DEFAULT_Z`, 7: Z after reset. floor(Z/2) after reset is `DEFAULT_Z/2`.

Ports:
- `sys_clk`  in  1  clock; all logic is on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `z_reconfig_i`  in  REF_WIDTH  new Z (W^s).
- `zHalf_reconfig_i`  in  REF_WIDTH  floor(Z/2) paired with `z_reconfig_i`.
- `cfg_load_i`  in  1  strobe that loads the Z pair.
- `clr_i`  in  1  synchronous clear of the accumulators and the layer counter.
- `in_valid_i`  in  1  input beat valid.
- `in_ready_o`  out  1  block can accept a beat.
- `shift_i`  in  CH_NUM*SHIFT_WIDTH  per-channel shift; channel c occupies `[c*SHIFT_WIDTH +: SHIFT_WIDTH]`.
- `out_valid_o`  out  1  output beat valid.
- `out_ready_i`  in  1  consumer accepts the output.
- `cumulative_shift_o`  out  CH_NUM*SHIFT_WIDTH  accumulated shift mod Z.
- `rot_amt_o`  out  CH_NUM*SHIFT_WIDTH  shortest rotation amount.
- `rot_dir_o`  out  CH_NUM  per channel: 0 = rotate by cum, 1 = rotate the opposite way by Z−cum.
- `layer_idx_o`  out  $clog2(LAYER_NUM)  layer index of the output beat.
- `iter_end_o`  out  1  output beat is the last layer of the iteration.
- `shift_err_o`  out  1  sticky illegal-input flag.

## Operation
- Accept condition: `in_valid_i && in_ready_o`.
- `in_ready_o = !out_valid_o || out_ready_i`. This is a single output register stage with no skid buffer.
- On accept, for each channel c: `sum = acc[c] + s[c]`, computed SHIFT_WIDTH+1 bits wide.
  - `cum = (sum >= Z) ? sum − Z : sum`.
  - `acc[c] <= cum`.
  - Register `cum` to `cumulative_shift_o`.
- Rotation: if `cum > zHalf` then `rot_dir = 1` and `rot_amt = Z − cum`; otherwise `rot_dir = 0` and `rot_amt = cum`.
- Illegal input: `s[c] >= Z` is treated as 0 for that channel and sets `shift_err_o`. The flag clears only on `rst` or on an accepted `cfg_load_i`.
- Layer counter:
  - The counter increments per accepted beat.
  - The output carries the counter value held before the increment.
  - `iter_end_o = (layer == LAYER_NUM−1)`.
  - On that beat the counter wraps to 0 and every `acc` is zeroed, so the next beat accumulates from 0.
- `clr_i`:
  - Zeroes `acc` and the layer counter.
  - Has priority over an accept in the same cycle; that beat's output is still produced, computed with acc=0 and layer 0.
  - Does not touch the output register or `shift_err_o`.
- `cfg_load_i`:
  - Honoured only when idle, i.e. `!out_valid_o && !in_valid_i`. Otherwise it is ignored.
  - If `z_reconfig_i == 0` it is ignored.
  - When honoured: latches Z and zHalf, zeroes `acc` and the layer counter, and clears `shift_err_o`.
- Output register: holds its value while `out_valid_o && !out_ready_i`.
- `out_valid_o`:
  - Set on accept.
  - Cleared when `out_ready_i` is high and no new accept occurs.

## Timing
- Latency: 1 cycle from accept to `out_valid_o`.
- Throughput: 1 beat/cycle while `out_ready_i` stays high.
- Reset values:
  - `out_valid_o=0`.
  - All data outputs 0.
  - `rot_dir_o=0`, `layer_idx_o=0`, `iter_end_o=0`, `shift_err_o=0`.
  - `acc=0`, layer counter 0.
  - Z=`DEFAULT_Z`, zHalf=`DEFAULT_Z/2`.
  - `in_ready_o=1` once `rst` is low.
- Reset asserted mid-stream: all state returns to reset values immediately (asynchronous); any in-flight beat is dropped.
- Back-to-back accepts use the `acc` value updated by the previous accept; there is no bubble.
- Output data is stable while stalled; it changes only in a cycle where an accept occurs.

## Test plan
- Reset, then beat shifts {1,2,3,6} with Z=7 → next cycle: cum {1,2,3,6}, rot_dir {0,0,0,1}, rot_amt {1,2,3,1}, layer 0, iter_end 0.
- Wrap-around: second beat {6,6,6,6} → cum {0,1,2,5}, rot_dir {0,0,0,1}, rot_amt {0,1,2,2}, layer 1.
- Backpressure: hold `out_ready_i=0` for 3 cycles with `in_valid_i=1` → `in_ready_o=0`; outputs frozen; acc unchanged. Release → the held beat drains, then the next beat is accepted in the same cycle.
- Iteration boundary with LAYER_NUM=3: beats {1},{1},{1},{1} on channel 0 → cum 1,2,3 with iter_end on the third beat; the fourth beat gives cum 1 at layer 0.
- Error and config:
  - shift 7 with Z=7 → that channel's cum equals its acc; `shift_err_o=1` and stays 1.
  - `cfg_load_i` with Z=5 and `out_valid_o=1` → ignored.
  - The same load when idle → accepted; `shift_err_o=0`; beat {4} gives rot_dir 1, rot_amt 1.
- Clear and reset: `clr_i` coincident with an accept of {3} after acc=2 → output cum 3, layer 0. Assert `rst` mid-stream → `out_valid_o` drops immediately; all outputs 0.
